// File: rtl/mmio_wr_queue.sv
// Elastic circular-buffer queue for MMIO writes to one register address, with
// occupancy and sticky overflow status. `MMIO_WR_QUEUE_DROP_CNT_EN adds drop_cnt.
module mmio_wr_queue #(
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned DATA_W     = 64,
    parameter logic [15:0] MATCH_ADDR = 16'h0020
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_valid,
    input  logic [15:0]                wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       overflow,
    input  logic                       ovf_clr,
    output logic [15:0]                drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [CW-1:0]     count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              hit, push, pop, drop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign out_valid = ~empty;
    assign out_data  = mem_q[rp_q];
    assign count     = count_q;
    assign overflow  = overflow_q;

    always_comb begin
        hit  = wr_valid && (wr_addr == MATCH_ADDR);
        pop  = out_valid && out_ready;
        // A pop in the same cycle frees the slot, so a full queue still accepts.
        push = hit && (!full || pop);
        drop = hit && full && !pop;

        wp_d = push ? wp_q + AW'(1) : wp_q;
        rp_d = pop  ? rp_q + AW'(1) : rp_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        overflow_d = overflow_q;
        if (drop)
            overflow_d = 1'b1;
        else if (ovf_clr)
            overflow_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push)
            mem_q[wp_q] <= wr_data;
    end

`ifdef MMIO_WR_QUEUE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            if (ovf_clr)
                drop_cnt_d = 16'd1;
            else if (drop_cnt_q != 16'hFFFF)
                drop_cnt_d = drop_cnt_q + 16'd1;
        end else if (ovf_clr) begin
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            drop_cnt_q <= '0;
        else
            drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_mmio_wr_queue.sv
// Directed vector-table bench for mmio_wr_queue (DEPTH=8); each row is one
// clock cycle of inputs followed by the expected registered state after the edge.
module tb_mmio_wr_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [63:0] wr_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        ovf_clr;
    logic [15:0] drop_cnt;

`ifdef MMIO_WR_QUEUE_DROP_CNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    mmio_wr_queue #(.DEPTH(8), .DATA_W(64), .MATCH_ADDR(16'h0020)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .count(count), .full(full), .empty(empty),
        .overflow(overflow), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        wv;
        logic [15:0] addr;
        logic [63:0] data;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [63:0] ed;
        logic [3:0]  ec;
        logic        eov;
        logic [15:0] edc;
    } vec_t;

    vec_t vecs[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    function automatic vec_t mk(logic r, logic wv, logic [15:0] a, logic [63:0] d,
                                logic rdy, logic clr, logic ev, logic [63:0] ed,
                                logic [3:0] ec, logic eov, logic [15:0] edc);
        vec_t v;
        v.rst_n = r; v.wv = wv; v.addr = a; v.data = d; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eov = eov; v.edc = edc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int unsigned idx);
        string tag;
        @(negedge clk);
        rst_n = v.rst_n; wr_valid = v.wv; wr_addr = v.addr; wr_data = v.data;
        out_ready = v.rdy; ovf_clr = v.clr;
        @(posedge clk);
        #1;
        n_vec++;
        tag = $sformatf("vec%0d", idx);
        chk({tag, ".count"},     64'(count),     64'(v.ec));
        chk({tag, ".full"},      64'(full),      64'(v.ec == 4'd8));
        chk({tag, ".empty"},     64'(empty),     64'(v.ec == 4'd0));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(v.ev));
        chk({tag, ".overflow"},  64'(overflow),  64'(v.eov));
        chk({tag, ".drop_cnt"},  64'(drop_cnt),  64'(DC_EN ? v.edc : 16'h0));
        if (v.ev)
            chk({tag, ".out_data"}, out_data, v.ed);
    endtask

    localparam logic [15:0] A  = 16'h0020;
    localparam logic [15:0] NA = 16'h0018;

    initial begin
        rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;

        // reset, three writes, drain
        vecs.push_back(mk(0, 0, A, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, A, 64'h11, 0, 0, 1, 64'h11, 1, 0, 0));
        vecs.push_back(mk(1, 1, A, 64'h22, 0, 0, 1, 64'h11, 2, 0, 0));
        vecs.push_back(mk(1, 1, A, 64'h33, 0, 0, 1, 64'h11, 3, 0, 0));
        vecs.push_back(mk(1, 0, A, 0, 1, 0, 1, 64'h22, 2, 0, 0));
        vecs.push_back(mk(1, 0, A, 0, 1, 0, 1, 64'h33, 1, 0, 0));
        vecs.push_back(mk(1, 0, A, 0, 1, 0, 0, 0, 0, 0, 0));
        // non-matching address; out_ready while empty
        vecs.push_back(mk(1, 1, NA, 64'hDEAD, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, A, 0, 1, 0, 0, 0, 0, 0, 0));
        // fill with 0..7
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, 1, A, 64'(i), 0, 0, 1, 64'h0, 4'(i + 1), 0, 0));
        // drop, clear, drop, clear-with-drop
        vecs.push_back(mk(1, 1, A, 64'h99, 0, 0, 1, 64'h0, 8, 1, 1));
        vecs.push_back(mk(1, 0, A, 0, 0, 1, 1, 64'h0, 8, 0, 0));
        vecs.push_back(mk(1, 1, A, 64'h99, 0, 0, 1, 64'h0, 8, 1, 1));
        vecs.push_back(mk(1, 1, A, 64'h77, 0, 1, 1, 64'h0, 8, 1, 1));
        // push while full with pop: accepted, no drop
        vecs.push_back(mk(1, 1, A, 64'hAA, 1, 0, 1, 64'h1, 8, 1, 1));
        // drain 1..7 then AA
        for (int j = 0; j < 8; j++)
            vecs.push_back(mk(1, 0, A, 0, 1, 0, (j < 7), (j < 6) ? 64'(j + 2) : 64'hAA,
                              4'(7 - j), 1, 1));
        // sustained push+pop for 20 cycles across pointer wrap
        for (int i = 0; i < 20; i++)
            vecs.push_back(mk(1, 1, A, 64'(i), 1, 0, 1, 64'(i), 1, 1, 1));
        vecs.push_back(mk(1, 0, A, 0, 1, 0, 0, 0, 0, 1, 1));
        // queue 5 entries, then reset with a write in the reset cycle
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 1, A, 64'(64'h50 + i), 0, 0, 1, 64'h50, 4'(i + 1), 1, 1));
        vecs.push_back(mk(0, 1, A, 64'hBAD, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, A, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[k])
            apply(vecs[k], k);

        // no same-cycle bypass: status unchanged before the edge, data visible after
        @(negedge clk);
        wr_valid = 1'b1; wr_addr = A; wr_data = 64'hC0FFEE; out_ready = 1'b1; ovf_clr = 1'b0;
        #1;
        n_vec++;
        chk("bypass.out_valid", 64'(out_valid), 64'h0);
        chk("bypass.count", 64'(count), 64'h0);
        @(posedge clk);
        #1;
        n_vec++;
        chk("latency.out_valid", 64'(out_valid), 64'h1);
        chk("latency.out_data", out_data, 64'hC0FFEE);
        // handshake stability while out_ready is low
        @(negedge clk);
        wr_valid = 1'b0; out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            chk("hold.out_valid", 64'(out_valid), 64'h1);
            chk("hold.out_data", out_data, 64'hC0FFEE);
            chk("hold.count", 64'(count), 64'h1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        chk("final.empty", 64'(empty), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
